// File: rtl/muxn_pkg.sv
// Shared constants and helpers for the N-way registered selector (muxn_skid).
package muxn_pkg;

    localparam int MUXN_MAX_N = 16;

    // Select width for an n-way choice; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/muxn_comb.sv
// Pure N-way, WIDTH-bit select. A select at or beyond N matches no input,
// so the result is all zeros and never X.
module muxn_comb import muxn_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int N     = 9,
    parameter int SELW  = sel_width(N)
) (
    input  logic [N*WIDTH-1:0] d_i,
    input  logic [SELW-1:0]    s_i,
    output logic [WIDTH-1:0]   y_o
);

    always_comb begin
        y_o = '0;
        for (int i = 0; i < N; i++) begin
            if (s_i == SELW'(i)) begin
                y_o = d_i[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/muxn_skid.sv
// N-way selector registered behind a valid/ready handshake with a 2-entry skid.
// Define MUXN_SEL_ERR_EN to build the sticky out-of-range select flag.
module muxn_skid import muxn_pkg::*; #(
    parameter int  WIDTH = 32,
    parameter int  N     = 9,
    localparam int SELW  = sel_width(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] d,
    input  logic [SELW-1:0]    s,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    // Handshake: a beat moves on a port only in a cycle where its valid and
    // ready are both high at the rising edge; a producer holding valid while
    // ready is low must keep d/s unchanged until the beat is taken.

    if (N < 2 || N > MUXN_MAX_N) begin : g_bad_n
        $error("muxn_skid: N must be in 2..%0d", MUXN_MAX_N);
    end

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } skid_entry_t;

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] y_q, y_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    skid_entry_t      skid_q, skid_d;
    logic             in_xfer, out_xfer, main_load;

    muxn_comb #(
        .WIDTH (WIDTH),
        .N     (N),
        .SELW  (SELW)
    ) u_comb (
        .d_i (d),
        .s_i (s),
        .y_o (sel_data)
    );

    assign in_xfer   = in_valid & in_ready_q;
    assign out_xfer  = out_valid_q & out_ready;
    assign main_load = ~out_valid_q | out_xfer;

    always_comb begin
        y_d         = y_q;
        out_valid_d = out_valid_q;
        skid_d      = skid_q;
        if (main_load) begin
            if (skid_q.valid) begin
                y_d          = skid_q.data;
                out_valid_d  = 1'b1;
                skid_d.valid = 1'b0;
            end else begin
                y_d         = sel_data;
                out_valid_d = in_xfer;
            end
        end
        // Main is occupied and stalled: park the new beat behind it.
        if (in_xfer && out_valid_q && !out_ready) begin
            skid_d.valid = 1'b1;
            skid_d.data  = sel_data;
        end
        in_ready_d = ~skid_d.valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            skid_q      <= '0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            skid_q      <= skid_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;

`ifdef MUXN_SEL_ERR_EN
    localparam logic [SELW:0] N_LIM = (SELW+1)'(N);

    logic sel_err_q, sel_err_d, sel_oor;

    assign sel_oor   = {1'b0, s} >= N_LIM;
    assign sel_err_d = sel_err_q | (in_xfer & sel_oor);

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`else
    assign sel_err = 1'b0;
`endif

endmodule
